// File: rtl/gcd_unit_param_pkg.sv
// Purpose: shared types and mux-select encodings for the gcd_unit_param slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, a-register and b-register mux select codes.
package gcd_unit_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // a-register input select
  localparam logic [1:0] A_MUX_LD  = 2'd0;  // operand a from request
  localparam logic [1:0] A_MUX_B   = 2'd1;  // swap: take b
  localparam logic [1:0] A_MUX_SUB = 2'd2;  // a - b

  // b-register input select
  localparam logic B_MUX_LD = 1'b0;  // operand b from request
  localparam logic B_MUX_A  = 1'b1;  // swap: take a

endpackage

// File: rtl/gcd_unit_param_if.sv
// Purpose: request/response val/rdy stream bundle for the GCD accelerator.
// Latency: n/a (wires only).
// Backpressure: istream_rdy / ostream_rdy carried here.
// Signals: istream_{val,rdy,msg={tag,a,b}}, ostream_{val,rdy,msg={tag,gcd}}.
// Modports: master = requester side, slave = accelerator side.
interface gcd_unit_param_if #(
  parameter int p_nbits     = 16,
  parameter int p_tag_nbits = 4
);

  logic                             istream_val;
  logic                             istream_rdy;
  logic [p_tag_nbits+2*p_nbits-1:0] istream_msg;
  logic                             ostream_val;
  logic                             ostream_rdy;
  logic [p_tag_nbits+p_nbits-1:0]   ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

endinterface

// File: rtl/gcd_unit_param_dpath.sv
// Purpose: GCD datapath - a/b/tag registers, swap/subtract muxes, comparators.
// Latency: registers update one cycle after the enables are asserted.
// Backpressure: none internally; enables come from the control FSM.
// Ports: clk, rst; i_a_en/i_b_en/i_tag_en, i_a_sel, i_b_sel, i_req_msg;
//        o_resp_msg={tag,a}, o_is_a_lt_b, o_is_b_zero.
module gcd_unit_param_dpath
  import gcd_unit_param_pkg::*;
#(
  parameter int p_nbits     = 16,
  parameter int p_tag_nbits = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_a_en,
  input  logic                             i_b_en,
  input  logic                             i_tag_en,
  input  logic [1:0]                       i_a_sel,
  input  logic                             i_b_sel,
  input  logic [p_tag_nbits+2*p_nbits-1:0] i_req_msg,
  output logic [p_tag_nbits+p_nbits-1:0]   o_resp_msg,
  output logic                             o_is_a_lt_b,
  output logic                             o_is_b_zero
);

  logic [p_nbits-1:0]     r_a, r_b;
  logic [p_tag_nbits-1:0] r_tag;

  logic [p_tag_nbits-1:0] w_req_tag;
  logic [p_nbits-1:0]     w_req_a, w_req_b;
  logic [p_nbits-1:0]     w_sub, w_a_next, w_b_next;

  assign {w_req_tag, w_req_a, w_req_b} = i_req_msg;

  // Only selected when a >= b, so this never wraps.
  assign w_sub = r_a - r_b;

  always_comb begin
    w_a_next = r_a;
    case (i_a_sel)
      A_MUX_LD:  w_a_next = w_req_a;
      A_MUX_B:   w_a_next = r_b;
      A_MUX_SUB: w_a_next = w_sub;
      default:   w_a_next = r_a;
    endcase
  end

  assign w_b_next = (i_b_sel == B_MUX_A) ? r_a : w_req_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
    end else begin
      if (i_a_en)   r_a   <= w_a_next;
      if (i_b_en)   r_b   <= w_b_next;
      if (i_tag_en) r_tag <= w_req_tag;
    end
  end

  assign o_is_a_lt_b = (r_a < r_b);
  assign o_is_b_zero = (r_b == '0);
  assign o_resp_msg  = {r_tag, r_a};

endmodule

// File: rtl/gcd_unit_param.sv
// Purpose: tagged subtract/swap Euclid GCD accelerator on a val/rdy stream.
// Latency: 1 + CALC steps from request transfer to ostream_val (min 2).
// Backpressure: response held stable while ostream_rdy=0; istream_rdy=ostream_rdy in DONE.
// Ports: clk, rst (sync, active-high); io (gcd_unit_param_if.slave);
//        stat_num_resp, stat_busy_cycles only when GCD_UNIT_PARAM_STATS_EN is defined.
module gcd_unit_param
  import gcd_unit_param_pkg::*;
#(
  parameter int p_nbits     = 16,
  parameter int p_tag_nbits = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gcd_unit_param_if.slave       io
`ifdef GCD_UNIT_PARAM_STATS_EN
  ,
  output logic [31:0]           stat_num_resp,
  output logic [31:0]           stat_busy_cycles
`endif
);

  state_e     r_state, w_state_next;
  logic       w_a_en, w_b_en, w_tag_en, w_b_sel;
  logic [1:0] w_a_sel;
  logic       w_in_rdy, w_out_vld;
  logic       w_is_a_lt_b, w_is_b_zero;

  gcd_unit_param_dpath #(
    .p_nbits     (p_nbits),
    .p_tag_nbits (p_tag_nbits)
  ) u_dpath (
    .clk         (clk),
    .rst         (rst),
    .i_a_en      (w_a_en),
    .i_b_en      (w_b_en),
    .i_tag_en    (w_tag_en),
    .i_a_sel     (w_a_sel),
    .i_b_sel     (w_b_sel),
    .i_req_msg   (io.istream_msg),
    .o_resp_msg  (io.ostream_msg),
    .o_is_a_lt_b (w_is_a_lt_b),
    .o_is_b_zero (w_is_b_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_rdy     = 1'b0;
    w_out_vld    = 1'b0;
    w_a_en       = 1'b0;
    w_b_en       = 1'b0;
    w_tag_en     = 1'b0;
    w_a_sel      = A_MUX_LD;
    w_b_sel      = B_MUX_LD;
    case (r_state)
      IDLE: begin
        w_in_rdy = 1'b1;
        if (io.istream_val) begin
          w_a_en       = 1'b1;
          w_b_en       = 1'b1;
          w_tag_en     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (w_is_a_lt_b) begin
          w_a_en  = 1'b1;
          w_b_en  = 1'b1;
          w_a_sel = A_MUX_B;
          w_b_sel = B_MUX_A;
        end else if (!w_is_b_zero) begin
          w_a_en  = 1'b1;
          w_a_sel = A_MUX_SUB;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_vld = 1'b1;
        // Freeing the result register lets a new request load in the same cycle.
        w_in_rdy  = io.ostream_rdy;
        if (io.ostream_rdy) begin
          if (io.istream_val) begin
            w_a_en       = 1'b1;
            w_b_en       = 1'b1;
            w_tag_en     = 1'b1;
            w_state_next = CALC;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = state_e'(2'bxx);
    endcase
  end

  assign io.istream_rdy = w_in_rdy;
  assign io.ostream_val = w_out_vld;

`ifdef GCD_UNIT_PARAM_STATS_EN
  logic [31:0] r_num_resp, r_busy_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_resp    <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (w_out_vld && io.ostream_rdy) r_num_resp    <= r_num_resp + 32'd1;
      if (r_state == CALC)             r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign stat_num_resp    = r_num_resp;
  assign stat_busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// Purpose: self-checking bench for gcd_unit_param (32-bit operands, 8-bit tags).
// Latency: n/a.
// Backpressure: drives ostream_rdy low for stretches to hold responses.
module tb_gcd_unit_param;

  localparam int NB = 32;
  localparam int TB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_unit_param_if #(.p_nbits(NB), .p_tag_nbits(TB)) vif ();

`ifdef GCD_UNIT_PARAM_STATS_EN
  logic [31:0] stat_num_resp, stat_busy_cycles;
`endif

  gcd_unit_param #(.p_nbits(NB), .p_tag_nbits(TB)) dut (
    .clk              (clk),
    .rst              (rst),
    .io               (vif)
`ifdef GCD_UNIT_PARAM_STATS_EN
    ,
    .stat_num_resp    (stat_num_resp),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  typedef struct {
    logic [TB-1:0] tag;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;
  logic [TB+NB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference GCD by remainder Euclid.
  function automatic logic [NB-1:0] ref_gcd(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Response monitor: every response transfer is compared with the scoreboard.
  always @(negedge clk) begin
    if (!rst && vif.ostream_val && vif.ostream_rdy) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0h required=none", vif.ostream_msg);
      end else begin
        chk("resp", 64'(vif.ostream_msg), 64'(exp_q.pop_front()));
      end
    end
  end

  // Present a request; call right after posedge+#1. Leaves istream_val high.
  task automatic send(input logic [TB-1:0] tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                      input logic [NB-1:0] exp, output bit overlap);
    int n = 0;
    overlap = 1'b0;
    vif.istream_val = 1'b1;
    vif.istream_msg = {tag, a, b};
    forever begin
      @(negedge clk);
      if (vif.istream_rdy) begin
        overlap = vif.ostream_val && vif.ostream_rdy;
        exp_q.push_back({tag, exp});
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=not_accepted required=accepted");
        vif.istream_val = 1'b0;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic req(input logic [TB-1:0] tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                     input logic [NB-1:0] exp);
    bit ov;
    send(tag, a, b, exp, ov);
    vif.istream_val = 1'b0;
  endtask

  task automatic wait_cnt(input string name, input int target);
    for (int i = 0; i < 5000 && resp_cnt < target; i++) @(posedge clk);
    #1;
    chk(name, 64'(resp_cnt), 64'(target));
  endtask

  vec_t vecs[9];

  initial begin
    bit   ov;
    int   base, bad;
    logic [TB+NB-1:0] held;

    vecs[0] = '{8'h03, 32'd15,         32'd5,          32'd5};
    vecs[1] = '{8'h09, 32'd27,         32'd15,         32'd3};
    vecs[2] = '{8'h11, 32'd0,          32'd0,          32'd0};
    vecs[3] = '{8'h12, 32'd7,          32'd0,          32'd7};
    vecs[4] = '{8'h13, 32'd0,          32'd7,          32'd7};
    vecs[5] = '{8'h21, 32'd21,         32'd21,         32'd21};
    vecs[6] = '{8'hFE, 32'hFFFF_FFFE,  32'h7FFF_FFFF,  32'h7FFF_FFFF};
    vecs[7] = '{8'h77, 32'd1000,       32'd75,         32'd25};
    vecs[8] = '{8'h80, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};

    vif.istream_val = 1'b0;
    vif.istream_msg = '0;
    vif.ostream_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_rdy", 64'(vif.istream_rdy), 64'd1);
    chk("reset_out_vld", 64'(vif.ostream_val), 64'd0);
    @(posedge clk); #1;

    // Table vectors, one at a time.
    foreach (vecs[i]) begin
      base = resp_cnt;
      req(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_cnt("vec_done", base + 1);
      @(posedge clk); #1;
    end

    // b=0 gives ostream_val exactly two cycles after the request transfer.
    base = resp_cnt;
    req(8'h44, 32'd7, 32'd0, 32'd7);
    @(negedge clk);
    chk("lat_cycle1_vld", 64'(vif.ostream_val), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_vld", 64'(vif.ostream_val), 64'd1);
    wait_cnt("lat_done", base + 1);
    @(posedge clk); #1;

    // Back-to-back: val held high, next request accepted with the prior response.
    base = resp_cnt;
    send(8'hA1, 32'd12, 32'd8,  32'd4, ov);
    send(8'hA2, 32'd49, 32'd14, 32'd7, ov);
    chk("b2b_overlap_2", 64'(ov), 64'd1);
    send(8'hA3, 32'd1,  32'd1,  32'd1, ov);
    chk("b2b_overlap_3", 64'(ov), 64'd1);
    vif.istream_val = 1'b0;
    wait_cnt("b2b_done", base + 3);
    @(posedge clk); #1;

    // Backpressure: response held for 10 cycles, then exactly one transfer.
    base = resp_cnt;
    vif.ostream_rdy = 1'b0;
    req(8'h5A, 32'd36, 32'd24, 32'd12);
    for (int i = 0; i < 200 && !vif.ostream_val; i++) @(negedge clk);
    chk("bp_vld", 64'(vif.ostream_val), 64'd1);
    held = vif.ostream_msg;
    chk("bp_msg", 64'(held), 64'({8'h5A, 32'd12}));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vif.ostream_msg !== held || vif.istream_rdy !== 1'b0 || vif.ostream_val !== 1'b1) bad++;
    end
    chk("bp_hold_bad_cycles", 64'(bad), 64'd0);
    chk("bp_no_transfer", 64'(resp_cnt), 64'(base));
    @(posedge clk); #1;
    vif.ostream_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_one_transfer", 64'(resp_cnt), 64'(base + 1));
    chk("bp_out_vld_after", 64'(vif.ostream_val), 64'd0);

    // Random pairs with a shared factor so the subtract loop stays short.
    for (int i = 0; i < 20; i++) begin
      logic [NB-1:0] g, a, b;
      g = NB'($urandom_range(1, 32'd80_000_000));
      a = g * NB'($urandom_range(0, 40));
      b = g * NB'($urandom_range(0, 40));
      base = resp_cnt;
      req(TB'($urandom_range(0, 255)), a, b, ref_gcd(a, b));
      wait_cnt("rand_done", base + 1);
      @(posedge clk); #1;
    end

    // Reset mid-CALC drops the in-flight request.
    base = resp_cnt;
    req(8'hEE, 32'd65535, 32'd1, 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_rdy", 64'(vif.istream_rdy), 64'd1);
    chk("rst_mid_out_vld", 64'(vif.ostream_val), 64'd0);
    repeat (100) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", 64'(resp_cnt), 64'(base));

`ifdef GCD_UNIT_PARAM_STATS_EN
    // (15,5): 3 subtracts + 1 swap + 1 finish = 5 CALC cycles; (7,0): 1.
    chk("stat_resp_after_rst", 64'(stat_num_resp), 64'd0);
    base = resp_cnt;
    req(8'h01, 32'd15, 32'd5, 32'd5);
    wait_cnt("stat_r1", base + 1);
    @(posedge clk); #1;
    req(8'h02, 32'd7, 32'd0, 32'd7);
    wait_cnt("stat_r2", base + 2);
    @(posedge clk); #1;
    chk("stat_num_resp", 64'(stat_num_resp), 64'd2);
    chk("stat_busy_cycles", 64'(stat_busy_cycles), 64'd6);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
